// File: rtl/dataset_loader.sv
// dataset_loader: streams host bytes into the pixel and label memories,
// then pulses start and holds off input until the processor reports done.
module dataset_loader #(
  parameter int PIXELS      = 64,
  parameter int NUM_SAMPLES = 750,
  parameter int DADDR_W     = 16,
  parameter int LADDR_W     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [7:0]         dmem_wdata,
  output logic               lmem_we,
  output logic [LADDR_W-1:0] lmem_addr,
  output logic [3:0]         lmem_wdata,
  output logic               start,
  input  logic               proc_done,
  output logic               busy,
  output logic               label_err
);

  typedef enum logic [2:0] {
    IDLE,
    PIXEL,
    LABEL,
    START,
    WAIT_DONE
  } state_t;

  localparam int PW = $clog2(PIXELS + 1);
  localparam logic [PW-1:0] PIX_LAST =
    PW'(PIXELS - 1);
  localparam logic [LADDR_W-1:0] SAMP_LAST =
    LADDR_W'(NUM_SAMPLES - 1);

  state_t state, state_d;
  logic [PW-1:0]      pix, pix_d;
  logic [LADDR_W-1:0] samp, samp_d;
  logic [DADDR_W-1:0] daddr, daddr_d;
  logic xfer;
  logic pix_wr, lab_wr;
  logic err_set, err_clr;

  assign xfer = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pix   <= '0;
      samp  <= '0;
      daddr <= '0;
    end else begin
      state <= state_d;
      pix   <= pix_d;
      samp  <= samp_d;
      daddr <= daddr_d;
    end
  end

  always_comb begin
    state_d = state;
    pix_d   = pix;
    samp_d  = samp;
    daddr_d = daddr;
    pix_wr  = 1'b0;
    lab_wr  = 1'b0;
    err_set = 1'b0;
    err_clr = 1'b0;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          pix_wr  = 1'b1;
          err_clr = 1'b1;
          daddr_d = daddr + 1'b1;
          pix_d   = PW'(1);
          state_d = (PIXELS == 1) ? LABEL : PIXEL;
        end
      end
      PIXEL: begin
        if (xfer) begin
          pix_wr  = 1'b1;
          daddr_d = daddr + 1'b1;
          pix_d   = pix + 1'b1;
          if (pix == PIX_LAST) state_d = LABEL;
        end
      end
      LABEL: begin
        if (xfer) begin
          lab_wr  = 1'b1;
          err_set = (in_data > 8'd9);
          if (samp == SAMP_LAST) begin
            state_d = START;
          end else begin
            samp_d  = samp + 1'b1;
            pix_d   = '0;
            state_d = PIXEL;
          end
        end
      end
      START: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (proc_done) begin
          state_d = IDLE;
          pix_d   = '0;
          samp_d  = '0;
          daddr_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // all outputs registered off the next state / accepted byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      start      <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      lmem_we    <= 1'b0;
      lmem_addr  <= '0;
      lmem_wdata <= '0;
      label_err  <= 1'b0;
    end else begin
      in_ready <= (state_d == IDLE) ||
                  (state_d == PIXEL) ||
                  (state_d == LABEL);
      busy     <= (state_d != IDLE);
      start    <= (state_d == START);
      dmem_we  <= pix_wr;
      lmem_we  <= lab_wr;
      if (pix_wr) begin
        dmem_addr  <= daddr;
        dmem_wdata <= in_data;
      end
      if (lab_wr) begin
        lmem_addr  <= samp;
        lmem_wdata <= in_data[3:0];
      end
      if (err_clr) label_err <= 1'b0;
      else if (err_set) label_err <= 1'b1;
    end
  end

endmodule
